bcd_countdown_core: RTL

Four-digit MM:SS BCD countdown engine for the egg timer. It sits between the cook-time setter, which supplies the preset digits, and the display mux / timer-on LED logic, which consume the live digits and the done flag. The block runs on a single fast clock: a 1 Hz enable tick replaces any divided clock, and a parameterised prescaler allows fast simulation. It owns the run/pause/done sequencing for the timer.

---
 rtl/egg_timer_pkg.sv | 21 ++
 rtl/bcd_mmss_dec.sv | 42 ++++
 rtl/bcd_countdown_core.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/egg_timer_pkg.sv
// Shared types and constants for the egg-timer countdown blocks.
package egg_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX    = 4'd9;

    // Saturate a captured digit to its legal maximum.
    function automatic bcd_t bcd_clamp(input bcd_t d, input bcd_t lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational MM:SS BCD decrement with borrow chain.
// 00:00 is returned unchanged; o_is_zero_next flags a 00:00 result.
module bcd_mmss_dec
    import egg_timer_pkg::*;
(
    input  logic [3:0] i_min_t,
    input  logic [3:0] i_min_u,
    input  logic [3:0] i_sec_t,
    input  logic [3:0] i_sec_u,
    output logic [3:0] o_min_t,
    output logic [3:0] o_min_u,
    output logic [3:0] o_sec_t,
    output logic [3:0] o_sec_u,
    output logic       o_is_zero_next
);

    // Borrow ripples from seconds units up to minutes tens.
    always_comb begin
        o_min_t = i_min_t;
        o_min_u = i_min_u;
        o_sec_t = i_sec_t;
        o_sec_u = i_sec_u;
        if (i_sec_u != 4'd0) begin
            o_sec_u = i_sec_u - 4'd1;
        end else if (i_sec_t != 4'd0) begin
            o_sec_u = DIGIT_MAX;
            o_sec_t = i_sec_t - 4'd1;
        end else if (i_min_u != 4'd0) begin
            o_sec_u = DIGIT_MAX;
            o_sec_t = SEC_TENS_MAX;
            o_min_u = i_min_u - 4'd1;
        end else if (i_min_t != 4'd0) begin
            o_sec_u = DIGIT_MAX;
            o_sec_t = SEC_TENS_MAX;
            o_min_u = DIGIT_MAX;
            o_min_t = i_min_t - 4'd1;
        end
    end

    assign o_is_zero_next = ({o_min_t, o_min_u, o_sec_t, o_sec_u} == 16'd0);

endmodule

// File: rtl/bcd_countdown_core.sv
// Four-digit MM:SS BCD countdown engine with run/pause/done sequencing.
// Optional alarm blinker after expiry is built when ALARM_BLINK_EN is defined;
// otherwise alarm is tied low and no alarm counter exists.
module bcd_countdown_core
    import egg_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1,
    parameter int MAX_MIN_TENS  = 9,
    parameter int ALARM_SECS    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       enable,
    input  logic       load,
    input  logic       start,
    input  logic [3:0] set_min_t,
    input  logic [3:0] set_min_u,
    input  logic [3:0] set_sec_t,
    input  logic [3:0] set_sec_u,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       running,
    output logic       count_done,
    output logic       done_pulse,
    output logic       alarm
);

    localparam int      PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam bcd_t    MIN_T_MAX  = bcd_t'(MAX_MIN_TENS);

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_min_t, r_min_u, r_sec_t, r_sec_u;
    logic          r_running, r_count_done, r_done_pulse;

    logic [3:0]    w_ld_min_t, w_ld_min_u, w_ld_sec_t, w_ld_sec_u;
    logic [3:0]    w_dec_min_t, w_dec_min_u, w_dec_sec_t, w_dec_sec_u;
    logic          w_dec_zero;
    logic          w_is_zero;
    logic          w_presc_wrap;
    logic [PW-1:0] w_presc_next;
    logic          w_run_dec;
    logic          w_enter_done;

    assign w_ld_min_t = bcd_clamp(set_min_t, MIN_T_MAX);
    assign w_ld_min_u = bcd_clamp(set_min_u, DIGIT_MAX);
    assign w_ld_sec_t = bcd_clamp(set_sec_t, SEC_TENS_MAX);
    assign w_ld_sec_u = bcd_clamp(set_sec_u, DIGIT_MAX);

    assign w_is_zero    = ({r_min_t, r_min_u, r_sec_t, r_sec_u} == 16'd0);
    assign w_presc_wrap = (r_presc == PRESC_LAST);
    assign w_presc_next = w_presc_wrap ? '0 : r_presc + PW'(1);

    // A second elapses only in an undisturbed RUN cycle (pause requests discard the tick).
    assign w_run_dec    = (r_state == RUN) && enable && !start && tick_in && w_presc_wrap;
    assign w_enter_done = w_run_dec && w_dec_zero;

    bcd_mmss_dec u_dec (
        .i_min_t        (r_min_t),
        .i_min_u        (r_min_u),
        .i_sec_t        (r_sec_t),
        .i_sec_u        (r_sec_u),
        .o_min_t        (w_dec_min_t),
        .o_min_u        (w_dec_min_u),
        .o_sec_t        (w_dec_sec_t),
        .o_sec_u        (w_dec_sec_u),
        .o_is_zero_next (w_dec_zero)
    );

    // Run/pause/done sequencing, digit storage, prescaler and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_presc      <= '0;
            r_min_t      <= 4'd0;
            r_min_u      <= 4'd0;
            r_sec_t      <= 4'd0;
            r_sec_u      <= 4'd0;
            r_running    <= 1'b0;
            r_count_done <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_min_t <= w_ld_min_t;
                        r_min_u <= w_ld_min_u;
                        r_sec_t <= w_ld_sec_t;
                        r_sec_u <= w_ld_sec_u;
                    end else if (start && enable && !w_is_zero) begin
                        r_state   <= RUN;
                        r_presc   <= '0;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    if (start || !enable) begin
                        r_state   <= PAUSE;
                        r_running <= 1'b0;
                    end else if (tick_in) begin
                        r_presc <= w_presc_next;
                        if (w_presc_wrap) begin
                            r_min_t <= w_dec_min_t;
                            r_min_u <= w_dec_min_u;
                            r_sec_t <= w_dec_sec_t;
                            r_sec_u <= w_dec_sec_u;
                            if (w_dec_zero) begin
                                r_state      <= DONE;
                                r_running    <= 1'b0;
                                r_count_done <= 1'b1;
                                r_done_pulse <= 1'b1;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (load) begin
                        r_state <= IDLE;
                        r_min_t <= w_ld_min_t;
                        r_min_u <= w_ld_min_u;
                        r_sec_t <= w_ld_sec_t;
                        r_sec_u <= w_ld_sec_u;
                    end else if (start && enable) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                DONE: begin
                    if (load) begin
                        r_state      <= IDLE;
                        r_count_done <= 1'b0;
                        r_min_t      <= w_ld_min_t;
                        r_min_u      <= w_ld_min_u;
                        r_sec_t      <= w_ld_sec_t;
                        r_sec_u      <= w_ld_sec_u;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign min_tens   = r_min_t;
    assign min_units  = r_min_u;
    assign sec_tens   = r_sec_t;
    assign sec_units  = r_sec_u;
    assign running    = r_running;
    assign count_done = r_count_done;
    assign done_pulse = r_done_pulse;

`ifdef ALARM_BLINK_EN
    localparam int AW = $clog2(ALARM_SECS + 1);

    logic          r_alarm;
    logic [AW-1:0] r_alarm_cnt;
    logic [PW-1:0] r_alarm_presc;

    // Blink: high on DONE entry, toggles each prescaled second for ALARM_SECS seconds, then low.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_alarm       <= 1'b0;
            r_alarm_cnt   <= '0;
            r_alarm_presc <= '0;
        end else if (w_enter_done) begin
            r_alarm       <= 1'b1;
            r_alarm_cnt   <= AW'(ALARM_SECS);
            r_alarm_presc <= '0;
        end else if ((r_state == DONE) && (r_alarm_cnt != '0) && tick_in) begin
            if (r_alarm_presc == PRESC_LAST) begin
                r_alarm_presc <= '0;
                r_alarm_cnt   <= r_alarm_cnt - AW'(1);
                r_alarm       <= (r_alarm_cnt == AW'(1)) ? 1'b0 : ~r_alarm;
            end else begin
                r_alarm_presc <= r_alarm_presc + PW'(1);
            end
        end
    end

    assign alarm = r_alarm;
`else
    assign alarm = 1'b0;
`endif

endmodule
